// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes engine.
// Accepts one 128-bit state over a valid/ready handshake. It replaces each byte
// with its FIPS-197 inverse S-box value, one byte per clock, and returns the
// result over a second valid/ready handshake.
// Build option: define INV_SUB_BYTES_4X_EN to run four lookups in parallel.
// This gives a 4-cycle latency instead of 16; ports and results are unchanged.
module inv_sub_bytes_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state,
    output logic         busy
);

`ifdef INV_SUB_BYTES_4X_EN
    localparam int LANES = 4;
    localparam int CNT_W = 2;
`else
    localparam int LANES = 1;
    localparam int CNT_W = 4;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Inverse S-box, entry 0 in the top byte; row r holds entries 16r..16r+15.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        // Entry x sits at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
        return INV_SBOX[{~x, 3'b000} +: 8];
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [0:127]       work_q, work_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [6:0]         bit_idx;

    // Next-state logic: handshake, per-cycle byte substitution and output flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        bit_idx     = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d     = in_state;
                    cnt_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                for (int j = 0; j < LANES; j++) begin
                    bit_idx = 7'((int'(cnt_q) * LANES + j) * 8);
                    work_d[bit_idx +: 8] = inv_sbox(work_q[bit_idx +: 8]);
                end
                cnt_d = cnt_q + 1'b1;
                // The counter wraps to zero on the same edge that enters DONE.
                if (cnt_q == '1) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // IDLE is always visited before the next acceptance.
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State, working register and registered outputs; reset wins in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Testbench for inv_sub_bytes_seq. The reference inverse S-box is derived here
// from GF(2^8) arithmetic, using the multiplicative inverse followed by the
// affine map, and is then inverted.
module tb_inv_sub_bytes_seq;

`ifdef INV_SUB_BYTES_4X_EN
    localparam int LAT     = 4;
    localparam int RST_CNT = 2;
`else
    localparam int LAT     = 16;
    localparam int RST_CNT = 7;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_state;
    logic         busy;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b = 8'h00;
        for (int c = 1; c < 256; c++)
            if (x != 8'h00 && gmul(x, 8'(c)) == 8'h01) b = 8'(c);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] model(input logic [0:127] st);
        logic [0:127] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tbl[st[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction with out_ready high; optional intruding in_valid pulse.
    task automatic run_txn(input string tag, input logic [0:127] st, input logic [0:127] exp,
                           input int intr_at, input logic [0:127] intr_st);
        int lat;
        chk({tag, "/in_ready_idle"}, 128'(in_ready), 128'(1));
        in_valid  = 1'b1;
        in_state  = st;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_state = '0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (intr_at != 0 && lat == intr_at) begin
                chk({tag, "/busy_run"}, 128'(busy), 128'(1));
                chk({tag, "/in_ready_run"}, 128'(in_ready), 128'(0));
                in_valid = 1'b1;
                in_state = intr_st;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "/latency"}, 128'(lat), 128'(LAT));
        chk({tag, "/out_state"}, out_state, exp);
        @(posedge clk); #1;
        chk({tag, "/out_valid_drop"}, 128'(out_valid), 128'(0));
        chk({tag, "/in_ready_back"}, 128'(in_ready), 128'(1));
        chk({tag, "/busy_idle"}, 128'(busy), 128'(0));
    endtask

    initial begin
        logic [0:127] st, st2, exp;
        int lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        for (int x = 0; x < 256; x++) fwd_tbl[x] = fwd_sbox(8'(x));
        for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst/in_ready", 128'(in_ready), 128'(1));
        chk("rst/out_valid", 128'(out_valid), 128'(0));
        chk("rst/busy", 128'(busy), 128'(0));
        chk("rst/out_state", out_state, 128'(0));

        // Directed vectors with hand-derived results.
        run_txn("all63", {16{8'h63}}, '0, 0, '0);
        run_txn("v014679", 128'h01467900000000000000000000000000,
                128'h0998af52525252525252525252525252, 0, '0);
        run_txn("v7c16", 128'h7c160000000000000000000000000000,
                128'h01ff5252525252525252525252525252, 0, '0);

        // Random states against the reference model.
        for (int i = 0; i < 8; i++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            run_txn("rand", st, model(st), 0, '0);
        end

        // Sweep S(x) through byte 5; it must come back as x.
        for (int x = 0; x < 256; x++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            st[40 +: 8] = fwd_tbl[x];
            exp = model(st);
            exp[40 +: 8] = 8'(x);
            run_txn("sweep", st, exp, 0, '0);
        end

        // in_valid pulsed with a different state during RUN is ignored.
        st  = {$urandom, $urandom, $urandom, $urandom};
        st2 = ~st;
        run_txn("intrude", st, model(st), (LAT > 3) ? 3 : 2, st2);

        // Backpressure: hold DONE for 10 cycles.
        st  = {$urandom, $urandom, $urandom, $urandom};
        exp = model(st);
        in_valid = 1'b1; in_state = st; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp/latency", 128'(lat), 128'(LAT));
        chk("bp/out_state", out_state, exp);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp/out_valid_hold", 128'(out_valid), 128'(1));
            chk("bp/out_state_hold", out_state, exp);
            chk("bp/in_ready_low", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp/out_valid_drop", 128'(out_valid), 128'(0));
        chk("bp/in_ready_back", 128'(in_ready), 128'(1));
        chk("bp/busy_idle", 128'(busy), 128'(0));

        // Reset in the middle of RUN discards the partial state.
        st = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1; in_state = st;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (RST_CNT) @(posedge clk);
        #1;
        chk("midrst/busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst/out_valid", 128'(out_valid), 128'(0));
        chk("midrst/busy", 128'(busy), 128'(0));
        chk("midrst/in_ready", 128'(in_ready), 128'(1));
        chk("midrst/out_state", out_state, 128'(0));
        st = {$urandom, $urandom, $urandom, $urandom};
        run_txn("after_rst", st, model(st), 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
